// File: rtl/arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter.
package arb_pkg;

    typedef enum logic {ARB, LOCK} arb_st_t;

    // Index width sized for the largest supported requester count.
    localparam int unsigned N_REQ_MAX = 8;
    localparam int unsigned IDX_W     = $clog2(N_REQ_MAX);

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [N_REQ_MAX-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ_MAX; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: rotate requests so ptr sits at bit 0, keep the lowest set bit,
// rotate the winner back into requester order.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   pe;
    logic [2*N_REQ-1:0] unrot;

    assign req_dbl = {req, req};
    assign rot     = N_REQ'(req_dbl >> ptr);
    assign pe      = rot & (~rot + N_REQ'(1));
    assign unrot   = {pe, pe} << ptr;
    assign gnt     = unrot[2*N_REQ-1 -: N_REQ];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with per-requester lock in front of one BRAM port;
// registers the winning access and routes read data back with a one-hot valid.
module bram_port_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int MEM_AW = 16,
    parameter int MEM_DW = 16,
    parameter int RD_LAT = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        we_i,
    input  logic [N_REQ*MEM_AW-1:0] addr_i,
    input  logic [N_REQ*MEM_DW-1:0] dt_i,
    input  logic [N_REQ-1:0]        lock_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        rd_vld_o,
    output logic [MEM_DW-1:0]       rd_dt_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [MEM_AW-1:0]       mem_addr_o,
    output logic [MEM_DW-1:0]       mem_dt_o,
    input  logic [MEM_DW-1:0]       mem_dt_i
);

    arb_st_t          st_q, st_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [N_REQ-1:0]  own_oh;
    logic              own_req;
    logic              acc;
    logic              acc_lock;
    logic              acc_we;
    logic [IDX_W-1:0]  acc_idx;
    logic [MEM_AW-1:0] acc_addr;
    logic [MEM_DW-1:0] acc_dt;

    // Stage 0 lines up with mem_en_o, stage RD_LAT with mem_dt_i.
    logic [N_REQ-1:0] tag_q [0:RD_LAT];

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_REQ-1)) ? '0 : i + IDX_W'(1);
    endfunction

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (pick_gnt)
    );

    assign own_oh   = N_REQ'(1) << owner_q;
    assign own_req  = |(req_i & own_oh);
    assign gnt_o    = (st_q == LOCK) ? (own_req ? own_oh : '0) : pick_gnt;
    assign acc      = |(req_i & gnt_o);
    assign acc_lock = |(lock_i & gnt_o);
    assign acc_idx  = onehot2idx(N_REQ_MAX'(gnt_o));

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        acc_we   = 1'b0;
        acc_addr = '0;
        acc_dt   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_o[k]) begin
                acc_we   = acc_we | we_i[k];
                acc_addr = acc_addr | addr_i[k*MEM_AW +: MEM_AW];
                acc_dt   = acc_dt | dt_i[k*MEM_DW +: MEM_DW];
            end
        end
    end

    always_comb begin
        st_d    = st_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (st_q)
            ARB: begin
                if (acc) begin
                    if (acc_lock) begin
                        owner_d = acc_idx;
                        st_d    = LOCK;
                    end else begin
                        ptr_d = inc_idx(acc_idx);
                    end
                end
            end
            LOCK: begin
                // Dropping the request or a final unlocked access both hand the port back.
                if (!own_req || !acc_lock) begin
                    ptr_d = inc_idx(owner_q);
                    st_d  = ARB;
                end
            end
            default: st_d = ARB;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q    <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            st_q    <= st_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_en_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_dt_o   <= '0;
        end else begin
            mem_en_o <= acc;
            mem_we_o <= acc & acc_we;
            if (acc) begin
                mem_addr_o <= acc_addr;
                mem_dt_o   <= acc_dt;
            end
        end
    end

    // NOTE: the tag array is reset (unlike a RAM) so in-flight reads are dropped on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
            rd_vld_o <= '0;
            rd_dt_o  <= '0;
        end else begin
            tag_q[0] <= (acc && !acc_we) ? gnt_o : '0;
            for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            rd_vld_o <= tag_q[RD_LAT];
            rd_dt_o  <= mem_dt_i;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench: two arbiters (RD_LAT 1 and 2) share stimulus; a transaction-level model
// predicts grants, memory-port traffic and read responses.
module tb_bram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [N-1:0]  req, we, lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] dt;

    logic [N-1:0]  gnt_a, gnt_b, vld_a, vld_b;
    logic [DW-1:0] rdt_a, rdt_b, mdt_a, mdt_b, mo_dt_a, mo_dt_b, stg_b;
    logic          en_a, en_b, mwe_a, mwe_b;
    logic [AW-1:0] ma_a, ma_b;

    bram_port_arbiter #(.N_REQ(N), .MEM_AW(AW), .MEM_DW(DW), .RD_LAT(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .dt_i(dt),
        .lock_i(lock), .gnt_o(gnt_a), .rd_vld_o(vld_a), .rd_dt_o(rdt_a), .mem_en_o(en_a),
        .mem_we_o(mwe_a), .mem_addr_o(ma_a), .mem_dt_o(mo_dt_a), .mem_dt_i(mdt_a)
    );

    bram_port_arbiter #(.N_REQ(N), .MEM_AW(AW), .MEM_DW(DW), .RD_LAT(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .dt_i(dt),
        .lock_i(lock), .gnt_o(gnt_b), .rd_vld_o(vld_b), .rd_dt_o(rdt_b), .mem_en_o(en_b),
        .mem_we_o(mwe_b), .mem_addr_o(ma_b), .mem_dt_o(mo_dt_b), .mem_dt_i(mdt_b)
    );

    // Memory emulation: one-cycle BRAM for dut_a, extra output register for dut_b.
    logic [DW-1:0] ram_a [65536];
    logic [DW-1:0] ram_b [65536];
    logic [DW-1:0] gold  [65536];

    always @(posedge clk) begin
        if (en_a) begin
            if (mwe_a) ram_a[ma_a] <= mo_dt_a;
            mdt_a <= ram_a[ma_a];
        end
        if (en_b) begin
            if (mwe_b) ram_b[ma_b] <= mo_dt_b;
            stg_b <= ram_b[ma_b];
        end
        mdt_b <= stg_b;
    end

    int checks = 0;
    int failures = 0;

    // Reference model state.
    int  m_ptr, m_owner, cyc;
    bit  m_locked;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dt;
    logic [N-1:0]  ev_a [8], ev_b [8];
    logic [DW-1:0] ed_a [8], ed_b [8];

    logic [N-1:0]  obs_gnt, obs_vld_a, obs_vld_b;
    logic          obs_en, obs_we;
    logic [DW-1:0] obs_dt_a, obs_dt_b;

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_locked = 0; e_en = 0; e_we = 0;
        for (int i = 0; i < 8; i++) begin
            ev_a[i] = '0; ev_b[i] = '0; ed_a[i] = '0; ed_b[i] = '0;
        end
    endtask

    function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r);
        if (m_locked) return r[m_owner] ? (N'(1) << m_owner) : '0;
        for (int i = 0; i < N; i++) begin
            if (r[(m_ptr + i) % N]) return N'(1) << ((m_ptr + i) % N);
        end
        return '0;
    endfunction

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0] l,
                        input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        logic [N-1:0] eg;
        logic acc, n_en, n_we;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_dt;
        int k, slot;
        @(negedge clk);
        req = r; we = w; lock = l; addr = a; dt = d;
        #1;
        eg = model_gnt(r);
        obs_gnt = gnt_a; obs_en = en_a; obs_we = mwe_a;
        obs_vld_a = vld_a; obs_dt_a = rdt_a; obs_vld_b = vld_b; obs_dt_b = rdt_b;
        slot = cyc % 8;
        checks++; if (gnt_a !== eg) begin failures++; $display("FAIL gnt_a cyc=%0d: got %b expected %b", cyc, gnt_a, eg); end
        checks++; if (gnt_b !== eg) begin failures++; $display("FAIL gnt_b cyc=%0d: got %b expected %b", cyc, gnt_b, eg); end
        checks++; if ({en_a, en_b} !== {e_en, e_en}) begin failures++; $display("FAIL mem_en cyc=%0d: got %b%b expected %b", cyc, en_a, en_b, e_en); end
        if (e_en) begin
            checks++;
            if ({mwe_a, ma_a, mo_dt_a} !== {e_we, e_addr, e_dt} || {mwe_b, ma_b, mo_dt_b} !== {e_we, e_addr, e_dt}) begin
                failures++;
                $display("FAIL mem_port cyc=%0d: got we=%b/%b addr=%h/%h dt=%h/%h expected we=%b addr=%h dt=%h",
                         cyc, mwe_a, mwe_b, ma_a, ma_b, mo_dt_a, mo_dt_b, e_we, e_addr, e_dt);
            end
        end
        checks++; if (vld_a !== ev_a[slot]) begin failures++; $display("FAIL rd_vld_a cyc=%0d: got %b expected %b", cyc, vld_a, ev_a[slot]); end
        if (ev_a[slot] != '0) begin
            checks++; if (rdt_a !== ed_a[slot]) begin failures++; $display("FAIL rd_dt_a cyc=%0d: got %h expected %h", cyc, rdt_a, ed_a[slot]); end
        end
        checks++; if (vld_b !== ev_b[slot]) begin failures++; $display("FAIL rd_vld_b cyc=%0d: got %b expected %b", cyc, vld_b, ev_b[slot]); end
        if (ev_b[slot] != '0) begin
            checks++; if (rdt_b !== ed_b[slot]) begin failures++; $display("FAIL rd_dt_b cyc=%0d: got %h expected %h", cyc, rdt_b, ed_b[slot]); end
        end
        ev_a[slot] = '0; ev_b[slot] = '0;

        acc = |(r & eg);
        n_en = acc; n_we = 1'b0; n_addr = e_addr; n_dt = e_dt; k = 0;
        if (acc) begin
            for (int j = 0; j < N; j++) if (eg[j]) k = j;
            n_we = w[k]; n_addr = a[k*AW +: AW]; n_dt = d[k*DW +: DW];
            if (w[k]) gold[n_addr] = n_dt;
            else begin
                ev_a[(cyc + 3) % 8] = eg; ed_a[(cyc + 3) % 8] = gold[n_addr];
                ev_b[(cyc + 4) % 8] = eg; ed_b[(cyc + 4) % 8] = gold[n_addr];
            end
        end
        if (m_locked) begin
            if (!r[m_owner] || !l[m_owner]) begin m_locked = 0; m_ptr = (m_owner + 1) % N; end
        end else if (acc) begin
            if (l[k]) begin m_locked = 1; m_owner = k; end
            else m_ptr = (k + 1) % N;
        end
        @(posedge clk);
        cyc++;
        e_en = n_en; e_we = n_we; e_addr = n_addr; e_dt = n_dt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; we = '0; lock = '0;
        #1;
        checks++;
        if ({gnt_a, vld_a, rdt_a, en_a, mwe_a, ma_a, mo_dt_a} !== '0 ||
            {gnt_b, vld_b, rdt_b, en_b, mwe_b, ma_b, mo_dt_b} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got a=%b/%b/%h/%b/%b/%h/%h b=%b/%b/%h/%b/%b/%h/%h expected all zero",
                     gnt_a, vld_a, rdt_a, en_a, mwe_a, ma_a, mo_dt_a, gnt_b, vld_b, rdt_b, en_b, mwe_b, ma_b, mo_dt_b);
        end
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_round_robin();
        logic [N*AW-1:0] a;
        for (int k = 0; k < N; k++) a[k*AW +: AW] = AW'(16'h0100 + k);
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, '0, '0, a, '0);
            checks++; if (obs_gnt !== (N'(1) << (i % 4))) begin failures++; $display("FAIL rr_order[%0d]: got %b expected %b", i, obs_gnt, N'(1) << (i % 4)); end
            checks++; if (obs_en !== (i >= 1)) begin failures++; $display("FAIL rr_en[%0d]: got %b expected %b", i, obs_en, i >= 1); end
        end
        step('0, '0, '0, '0, '0);
        checks++; if (obs_en !== 1'b1) begin failures++; $display("FAIL rr_en_last: got %b expected 1", obs_en); end
        step('0, '0, '0, '0, '0);
        checks++; if (obs_en !== 1'b0) begin failures++; $display("FAIL rr_en_after: got %b expected 0", obs_en); end
    endtask

    task automatic test_read_return();
        logic [N*AW-1:0] a;
        a = '0; a[2*AW +: AW] = 16'h0010;
        step(4'b0100, '0, '0, a, '0);
        checks++; if (obs_gnt !== 4'b0100) begin failures++; $display("FAIL rdret_gnt: got %b expected 0100", obs_gnt); end
        idle(3);
        checks++; if (obs_vld_a !== 4'b0100 || obs_dt_a !== 16'hBEEF) begin
            failures++; $display("FAIL rdret_resp: got vld=%b dt=%h expected vld=0100 dt=beef", obs_vld_a, obs_dt_a);
        end
        idle(2);
    endtask

    task automatic test_lock_burst();
        logic [N-1:0] exp_g [6];
        logic [N-1:0] rq [6];
        logic [N-1:0] lk [6];
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
        rq    = '{4'b0010, 4'b1011, 4'b1011, 4'b1011, 4'b1001, 4'b0001};
        lk    = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            step(rq[i], '0, lk[i], {16'h0033, 16'h0022, 16'h0011, 16'h0000}, '0);
            checks++; if (obs_gnt !== exp_g[i]) begin failures++; $display("FAIL lock_burst[%0d]: got %b expected %b", i, obs_gnt, exp_g[i]); end
        end
        idle(4);
    endtask

    task automatic test_lock_drop();
        step(4'b1000, '0, 4'b1000, '0, '0);
        checks++; if (obs_gnt !== 4'b1000) begin failures++; $display("FAIL lockdrop_take: got %b expected 1000", obs_gnt); end
        step(4'b0110, '0, 4'b1000, '0, '0);
        checks++; if (obs_gnt !== 4'b0000) begin failures++; $display("FAIL lockdrop_idle: got %b expected 0000", obs_gnt); end
        step(4'b0110, '0, '0, '0, '0);
        checks++; if (obs_gnt !== 4'b0010) begin failures++; $display("FAIL lockdrop_next: got %b expected 0010", obs_gnt); end
        step(4'b0100, '0, '0, '0, '0);
        idle(4);
    endtask

    task automatic test_write_read();
        step(4'b0001, 4'b0001, '0, {48'h0, 16'h0005}, {48'h0, 16'h1234});
        step(4'b0010, '0, '0, {32'h0, 16'h0005, 16'h0}, '0);
        checks++; if ({obs_en, obs_we} !== 2'b11) begin failures++; $display("FAIL wr_we: got en=%b we=%b expected 1 1", obs_en, obs_we); end
        step('0, '0, '0, '0, '0);
        checks++; if ({obs_en, obs_we} !== 2'b10) begin failures++; $display("FAIL rd_we: got en=%b we=%b expected 1 0", obs_en, obs_we); end
        idle(2);
        checks++; if (obs_vld_a !== 4'b0010 || obs_dt_a !== 16'h1234) begin
            failures++; $display("FAIL wr_rd_a: got vld=%b dt=%h expected 0010 1234", obs_vld_a, obs_dt_a);
        end
        idle(1);
        checks++; if (obs_vld_b !== 4'b0010 || obs_dt_b !== 16'h1234) begin
            failures++; $display("FAIL wr_rd_b: got vld=%b dt=%h expected 0010 1234", obs_vld_b, obs_dt_b);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_read();
        step(4'b0100, '0, '0, {16'h0, 16'h0010, 32'h0}, '0);
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step('0, '0, '0, '0, '0);
            checks++; if ({obs_vld_a, obs_vld_b} !== '0) begin failures++; $display("FAIL rst_drop[%0d]: got %b %b expected 0000 0000", i, obs_vld_a, obs_vld_b); end
        end
        step(4'b1111, '0, '0, '0, '0);
        checks++; if (obs_gnt !== 4'b0001) begin failures++; $display("FAIL rst_prio: got %b expected 0001", obs_gnt); end
        idle(5);
    endtask

    task automatic test_random(input int n_cyc, input bit use_lock);
        logic [N-1:0] r, w, l;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        int wait_cnt [N];
        r = '0; w = '0; l = '0; a = '0; d = '0;
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        for (int c = 0; c < n_cyc; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!r[k] && $urandom_range(99) < 60) begin
                    r[k] = 1'b1;
                    w[k] = 1'($urandom_range(1));
                    a[k*AW +: AW] = AW'($urandom_range(31));
                    d[k*DW +: DW] = DW'($urandom);
                    l[k] = use_lock && ($urandom_range(99) < 30);
                    wait_cnt[k] = 0;
                end
            end
            step(r, w, l, a, d);
            for (int k = 0; k < N; k++) begin
                if (r[k] && obs_gnt[k]) begin
                    if (!use_lock) begin
                        checks++;
                        if (wait_cnt[k] > N - 1) begin failures++; $display("FAIL fairness req%0d: waited %0d accesses, limit %0d", k, wait_cnt[k], N - 1); end
                    end
                    r[k] = 1'b0;
                end else if (r[k] && |(obs_gnt & r)) begin
                    wait_cnt[k]++;
                end
            end
        end
        idle(6);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; we = '0; lock = '0; addr = '0; dt = '0;
        mdt_a = '0; mdt_b = '0; stg_b = '0; cyc = 0;
        for (int i = 0; i < 65536; i++) begin
            ram_a[i] = DW'(i * 7 + 3); ram_b[i] = DW'(i * 7 + 3); gold[i] = DW'(i * 7 + 3);
        end
        ram_a[16'h0010] = 16'hBEEF; ram_b[16'h0010] = 16'hBEEF; gold[16'h0010] = 16'hBEEF;
        model_reset();

        test_reset();
        test_round_robin();
        test_read_return();
        test_lock_burst();
        test_lock_drop();
        test_write_read();
        test_reset_mid_read();
        test_random(1500, 1'b0);
        test_random(1500, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
